axi_wr_master: RTL and testbench
================================

AXI_WR_MASTER -- requirements
Module: axi_wr_master

Interface
REQ-001 SHALL have parameter AWID, default 4'h0: ID driven on AWID and WID.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: maximum bursts in flight (command accepted, final B not yet received).
REQ-003 SHALL have ports clk in 1 (rising edge) and rst in 1 (asynchronous, active-high reset).
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_addr in 32, cmd_len in 4 (beats-1), cmd_incr in 1 (1=INCR, 0=FIXED).
REQ-005 SHALL have ports wd_valid in 1, wd_ready out 1, wd_data in 64: write data stream.
REQ-006 SHALL have ports AWVALID out 1, AWREADY in 1, AWADDR out 32, AWLEN out 4, AWSIZE out 3, AWBURST out 2, AWID out 4.
REQ-007 SHALL have ports WVALID out 1, WREADY in 1, WDATA out 64, WSTRB out 8, WLAST out 1, WID out 4.
REQ-008 SHALL have ports BVALID in 1, BREADY out 1, BRESP in 2, BID in 4.
REQ-009 SHALL have ports busy out 1, err out 1 (sticky), err_clr in 1, resp_cnt out 8 (B handshakes, wraps at 255->0).

Function
REQ-010 AW FSM SHALL have states AW_IDLE and AW_SEND; AW_IDLE->AW_SEND on cmd handshake; AW_SEND->AW_IDLE on AWVALID&AWREADY.
REQ-011 cmd_ready SHALL be 1 only in AW_IDLE, with outstanding < MAX_OUTSTANDING and the length FIFO not full.
REQ-012 On cmd handshake: AWADDR, AWLEN registered from cmd; AWBURST = cmd_incr ? 2'b01 : 2'b00; AWVALID=1 next cycle, held with stable payload until AWREADY.
REQ-013 AWSIZE SHALL be 3'b011; WSTRB SHALL be 8'hFF; AWID=WID=AWID parameter.
REQ-014 Every cmd handshake SHALL push cmd_len into an internal length FIFO of depth MAX_OUTSTANDING.
REQ-015 W FSM SHALL have states W_IDLE and W_BURST; W_IDLE->W_BURST when length FIFO non-empty (pop, load beat counter 0, store len); W_BURST->W_IDLE on handshake of last beat.
REQ-016 In W_BURST: WVALID=wd_valid, WDATA=wd_data, wd_ready=WREADY (combinational); in W_IDLE both SHALL be 0.
REQ-017 WLAST SHALL be 1 when beat counter == stored len; counter SHALL increment on each W handshake.
REQ-018 W beats SHALL be issued no earlier than the AW handshake of the same burst is started (W may complete before AWREADY).
REQ-019 Outstanding counter SHALL increment on AW handshake, decrement on final expected B handshake; simultaneous events SHALL leave it unchanged.
REQ-020 BREADY SHALL be 1 whenever outstanding > 0, else 0.
REQ-021 B handshake with BRESP != 2'b00 or BID != AWID SHALL set err.
REQ-022 BVALID while outstanding == 0 SHALL set err; counter SHALL not underflow.
REQ-023 err_clr SHALL clear err next cycle; set condition in the same cycle SHALL win.
REQ-024 busy SHALL be 1 when AW FSM != AW_IDLE, W FSM != W_IDLE, length FIFO non-empty, or outstanding > 0.

Reset
REQ-025 While rst=1: AWVALID, WVALID, BREADY, cmd_ready, wd_ready, busy, err = 0; resp_cnt, outstanding, beat counter = 0; FSMs in AW_IDLE/W_IDLE; length FIFO empty.
REQ-026 Reset asserted mid-burst SHALL abandon the burst; no beats or responses resume after release.
REQ-027 cmd_ready SHALL become 1 on the first clk edge after rst deasserts.

Configuration
REQ-028 Macro AXI_WR_BRESP_PER_BEAT_EN defined: slave returns one B per W beat; outstanding SHALL count beats (add AWLEN+1 on AW handshake, subtract 1 per B); MAX_OUTSTANDING limits beats and cmd_ready additionally requires outstanding+cmd_len+1 <= MAX_OUTSTANDING*16.
REQ-029 Macro undefined: one B per burst; outstanding counts bursts per REQ-019.

Verification
REQ-030 Single beat: cmd addr=0x100, len=0, AWREADY=1 -> one AW (AWLEN=0, AWBURST=01), one W with WLAST=1, B OKAY -> resp_cnt=1, err=0, busy=0.
REQ-031 INCR burst len=3, WREADY toggling every other cycle -> 4 W beats in order, WLAST only on 4th, WDATA unchanged while stalled.
REQ-032 AWREADY held 0 for 5 cycles -> AWVALID/AWADDR stable 5 cycles, cmd_ready=0 throughout.
REQ-033 Issue MAX_OUTSTANDING=4 bursts with BVALID=0 -> cmd_ready=0 after 4th; one B OKAY -> cmd_ready=1 next cycle.
REQ-034 BRESP=2'b10 on a B -> err=1 and stays set; err_clr pulse with no error -> err=0; unsolicited BVALID at idle -> err=1.
REQ-035 rst pulse during beat 2 of len=7 burst -> all outputs 0, outstanding=0; new len=0 command completes normally.

Source files
------------

// File: rtl/axi_wr_master.sv
// AXI write master: cmd accepted -> AW valid next cycle; W streams wd_* once that AW is up (wd_ready = WREADY); cmd stalls while AW pending, outstanding full or length FIFO full.
// AXI_WR_BRESP_PER_BEAT_EN: slave returns one B per W beat and the outstanding counter tracks beats instead of bursts.
module axi_wr_master #(
    parameter logic [3:0] AXI_ID          = 4'h0,
    parameter int         MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic        cmd_incr,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [63:0] wd_data,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic [3:0]  AWID,
    output logic        WVALID,
    input  logic        WREADY,
    output logic [63:0] WDATA,
    output logic [7:0]  WSTRB,
    output logic        WLAST,
    output logic [3:0]  WID,
    input  logic        BVALID,
    output logic        BREADY,
    input  logic [1:0]  BRESP,
    input  logic [3:0]  BID,
    output logic        busy,
    output logic        err,
    input  logic        err_clr,
    output logic [7:0]  resp_cnt
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING * 16 + 1);

    typedef enum logic {AW_IDLE, AW_SEND} aw_state_t;
    typedef enum logic {W_IDLE, W_BURST} w_state_t;

    aw_state_t     aw_state_q, aw_state_d;
    w_state_t      w_state_q, w_state_d;
    logic          awvalid_q, awvalid_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [3:0]    awlen_q, awlen_d;
    logic [1:0]    awburst_q, awburst_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [3:0]    beat_q, beat_d;
    logic [3:0]    wlen_q, wlen_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [7:0]    resp_cnt_q, resp_cnt_d;
    logic [3:0]    fifo_mem [MAX_OUTSTANDING];

    logic cmd_hs, aw_hs, w_hs, b_hs, fifo_pop, err_set;

`ifdef AXI_WR_BRESP_PER_BEAT_EN
    // Burst must fit in the beat budget; depends on the live cmd_len so it stays combinational.
    logic cmd_fit;
    assign cmd_fit   = ({1'b0, outst_q} + (OW+1)'(cmd_len) + (OW+1)'(1)) <= (OW+1)'(MAX_OUTSTANDING * 16);
    assign cmd_ready = cmd_ready_q && cmd_fit;
`else
    assign cmd_ready = cmd_ready_q;
`endif

    assign cmd_hs   = cmd_valid && cmd_ready;
    assign aw_hs    = awvalid_q && AWREADY;
    assign w_hs     = WVALID && WREADY;
    assign b_hs     = BVALID && BREADY;
    assign fifo_pop = (w_state_q == W_IDLE) && (cnt_q != '0);
    assign err_set  = (b_hs && ((BRESP != 2'b00) || (BID != AXI_ID))) || (BVALID && (outst_q == '0));

    always_comb begin
        aw_state_d = aw_state_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awburst_d  = awburst_q;
        w_state_d  = w_state_q;
        beat_d     = beat_q;
        wlen_d     = wlen_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        case (aw_state_q)
            AW_IDLE: if (cmd_hs) begin
                aw_state_d = AW_SEND;
                awvalid_d  = 1'b1;
                awaddr_d   = cmd_addr;
                awlen_d    = cmd_len;
                awburst_d  = cmd_incr ? 2'b01 : 2'b00;
            end
            AW_SEND: if (AWREADY) begin
                aw_state_d = AW_IDLE;
                awvalid_d  = 1'b0;
            end
            default: aw_state_d = AW_IDLE;
        endcase

        case (w_state_q)
            W_IDLE: if (fifo_pop) begin
                w_state_d = W_BURST;
                beat_d    = 4'd0;
                wlen_d    = fifo_mem[rd_ptr_q];
            end
            W_BURST: if (w_hs) begin
                beat_d = beat_q + 4'd1;
                if (WLAST) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        if (cmd_hs)   wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (fifo_pop) rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        cnt_d = cnt_q + CW'(cmd_hs) - CW'(fifo_pop);

`ifdef AXI_WR_BRESP_PER_BEAT_EN
        outst_d = outst_q + (aw_hs ? (OW'(awlen_q) + OW'(1)) : '0) - OW'(b_hs);
`else
        outst_d = outst_q + OW'(aw_hs) - OW'(b_hs);
`endif

        err_d       = err_set || (err_q && !err_clr);
        resp_cnt_d  = resp_cnt_q + {7'd0, b_hs};
        cmd_ready_d = (aw_state_d == AW_IDLE) && (outst_d < OW'(MAX_OUTSTANDING)) &&
                      (cnt_d < CW'(MAX_OUTSTANDING));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_state_q  <= AW_IDLE;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awburst_q   <= '0;
            w_state_q   <= W_IDLE;
            beat_q      <= '0;
            wlen_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            resp_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            aw_state_q  <= aw_state_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awburst_q   <= awburst_d;
            w_state_q   <= w_state_d;
            beat_q      <= beat_d;
            wlen_q      <= wlen_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
            resp_cnt_q  <= resp_cnt_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_hs) fifo_mem[wr_ptr_q] <= cmd_len;
    end

    assign AWVALID  = awvalid_q;
    assign AWADDR   = awaddr_q;
    assign AWLEN    = awlen_q;
    assign AWSIZE   = 3'b011;
    assign AWBURST  = awburst_q;
    assign AWID     = AXI_ID;
    assign WVALID   = (w_state_q == W_BURST) && wd_valid;
    assign wd_ready = (w_state_q == W_BURST) && WREADY;
    assign WDATA    = (w_state_q == W_BURST) ? wd_data : '0;
    assign WLAST    = (w_state_q == W_BURST) && (beat_q == wlen_q);
    assign WSTRB    = 8'hFF;
    assign WID      = AXI_ID;
    assign BREADY   = (outst_q != '0);
    assign busy     = (aw_state_q != AW_IDLE) || (w_state_q != W_IDLE) || (cnt_q != '0) || (outst_q != '0);
    assign err      = err_q;
    assign resp_cnt = resp_cnt_q;
endmodule

// File: tb/tb_axi_wr_master.sv
// Bench for axi_wr_master: directed commands push expected AW/W payloads into queues; a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_axi_wr_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_incr;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN, AWID;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        WVALID, WREADY, WLAST;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic [3:0]  WID;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic [3:0]  BID;
    logic        busy, err, err_clr;
    logic [7:0]  resp_cnt;

    int total = 0;
    int bad   = 0;
    logic [44:0] exp_aw[$];
    logic [76:0] exp_w[$];
    logic [63:0] data_q[$];
    logic        wr_toggle = 1'b0;
    logic        wr_level  = 1'b1;

    axi_wr_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WID(WID),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
        .busy(busy), .err(err), .err_clr(err_clr), .resp_cnt(resp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: compares every AW/W handshake against the scoreboard and checks payload hold while stalled.
    logic        aw_stall = 1'b0, w_stall = 1'b0;
    logic [31:0] aw_prev  = '0;
    logic [63:0] w_prev   = '0;
    always @(negedge clk) begin
        if (rst) begin
            aw_stall <= 1'b0;
            w_stall  <= 1'b0;
        end else begin
            if (aw_stall) begin
                check("aw_hold_valid", AWVALID, 1);
                check("aw_hold_addr", AWADDR, aw_prev);
            end
            if (AWVALID && AWREADY) begin
                if (exp_aw.size() == 0) check("aw_unexpected", AWVALID, 0);
                else check("aw_payload", {AWADDR, AWLEN, AWSIZE, AWBURST, AWID}, exp_aw.pop_front());
            end
            if (w_stall && WVALID) check("w_hold_data", WDATA, w_prev);
            if (WVALID && WREADY) begin
                if (exp_w.size() == 0) check("w_unexpected", WVALID, 0);
                else check("w_payload", {WDATA, WLAST, WSTRB, WID}, exp_w.pop_front());
            end
            aw_stall <= AWVALID && !AWREADY;
            aw_prev  <= AWADDR;
            w_stall  <= WVALID && !WREADY;
            w_prev   <= WDATA;
        end
    end

    // Data source: presents the head of data_q and retires it after a wd handshake.
    initial begin
        logic hs;
        wd_valid = 1'b0;
        wd_data  = '0;
        forever begin
            @(negedge clk);
            hs = wd_valid && wd_ready;
            @(posedge clk);
            #1;
            if (hs && data_q.size() > 0) data_q.delete(0);
            wd_valid = (data_q.size() > 0);
            wd_data  = (data_q.size() > 0) ? data_q[0] : 64'h0;
        end
    end

    initial begin
        WREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            WREADY = wr_toggle ? ~WREADY : wr_level;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic issue_cmd(input logic [31:0] a, input logic [3:0] l, input logic inc, input logic [63:0] base);
        int n;
        @(posedge clk);
        #1;
        exp_aw.push_back({a, l, 3'b011, (inc ? 2'b01 : 2'b00), 4'h0});
        for (int i = 0; i <= int'(l); i++) begin
            data_q.push_back(base + 64'(i));
            exp_w.push_back({base + 64'(i), (i == int'(l)), 8'hFF, 4'h0});
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_incr  = inc;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (n == 100) timeout_fail("cmd_accept");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_w.size() == 0 && exp_aw.size() == 0) break;
        end
        if (n == 300) timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [1:0] r, input logic [3:0] id);
        int n;
        @(posedge clk);
        #1;
        BVALID = 1'b1;
        BRESP  = r;
        BID    = id;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (BREADY) break;
        end
        if (n == 50) timeout_fail("b_accept");
        @(posedge clk);
        #1;
        BVALID = 1'b0;
        BRESP  = 2'b00;
        BID    = 4'h0;
    endtask

    task automatic clear_err();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", err, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, AWVALID, 0);
        check({tag, "_wvalid"}, WVALID, 0);
        check({tag, "_bready"}, BREADY, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_wd_ready"}, wd_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_resp_cnt"}, resp_cnt, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_incr = 1'b0;
        AWREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = 4'h0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Single-beat burst
        AWREADY = 1'b1;
        issue_cmd(32'h100, 4'd0, 1'b1, 64'hA000);
        wait_drain();
        @(negedge clk);
        check("t1_bready", BREADY, 1);
        check("t1_busy_waiting_b", busy, 1);
        send_b(2'b00, 4'h0);
        @(negedge clk);
        check("t1_resp_cnt", resp_cnt, 1);
        check("t1_err", err, 0);
        check("t1_busy", busy, 0);

        // INCR len=3 with WREADY toggling
        wr_toggle = 1'b1;
        issue_cmd(32'h2000, 4'd3, 1'b1, 64'hB000);
        wait_drain();
        wr_toggle = 1'b0;
        send_b(2'b00, 4'h0);
        @(negedge clk);
        check("t2_resp_cnt", resp_cnt, 2);

        // AWREADY held low for 5 cycles, FIXED burst
        AWREADY = 1'b0;
        issue_cmd(32'h3000, 4'd1, 1'b0, 64'hC000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_awvalid", AWVALID, 1);
            check("t3_awaddr", AWADDR, 32'h3000);
            check("t3_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk);
        #1;
        AWREADY = 1'b1;
        wait_drain();
        send_b(2'b00, 4'h0);
        @(negedge clk);
        check("t3_resp_cnt", resp_cnt, 3);

        // Four bursts in flight with no B
        for (int i = 0; i < 4; i++) issue_cmd(32'h4000 + 32'(i * 16), 4'd0, 1'b1, 64'hD000 + 64'(i * 16));
        wait_drain();
        repeat (3) begin
            @(negedge clk);
            check("t4_cmd_ready_full", cmd_ready, 0);
            check("t4_bready", BREADY, 1);
        end
        send_b(2'b00, 4'h0);
        @(negedge clk);
        check("t4_cmd_ready_after_b", cmd_ready, 1);
        repeat (3) send_b(2'b00, 4'h0);
        @(negedge clk);
        check("t4_resp_cnt", resp_cnt, 7);
        check("t4_busy", busy, 0);
        check("t4_err", err, 0);

        // Error responses
        issue_cmd(32'h5000, 4'd0, 1'b1, 64'hE000);
        wait_drain();
        send_b(2'b10, 4'h0);
        @(negedge clk);
        check("t5_err_slverr", err, 1);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", err, 1);
        check("t5_resp_cnt", resp_cnt, 8);
        clear_err();
        issue_cmd(32'h5100, 4'd0, 1'b1, 64'hE100);
        wait_drain();
        send_b(2'b00, 4'h5);
        @(negedge clk);
        check("t5_err_bid", err, 1);
        clear_err();
        @(posedge clk);
        #1;
        BVALID = 1'b1;
        @(negedge clk);
        check("t5_unsol_bready", BREADY, 0);
        @(posedge clk);
        #1;
        BVALID = 1'b0;
        @(negedge clk);
        check("t5_err_unsol", err, 1);
        check("t5_resp_cnt_unsol", resp_cnt, 9);
        check("t5_no_underflow", BREADY, 0);
        check("t5_busy_unsol", busy, 0);
        @(posedge clk);
        #1;
        BVALID = 1'b1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        BVALID = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        check("t5_err_set_wins", err, 1);
        clear_err();

        // Reset in the middle of a len=7 burst
        issue_cmd(32'h6000, 4'd7, 1'b1, 64'hF000);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (exp_w.size() <= 6) break;
        end
        if (n == 100) timeout_fail("t6_beat2");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        exp_aw.delete();
        exp_w.delete();
        data_q.delete();
        check_reset_outputs("t6_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_q.push_back(64'hDEAD);
        data_q.push_back(64'hBEEF);
        repeat (6) begin
            @(negedge clk);
            check("t6_no_resume_wd_ready", wd_ready, 0);
            check("t6_no_resume_bready", BREADY, 0);
        end
        data_q.delete();
        issue_cmd(32'h7000, 4'd0, 1'b1, 64'h7700);
        wait_drain();
        send_b(2'b00, 4'h0);
        @(negedge clk);
        check("t6_resp_cnt", resp_cnt, 1);
        check("t6_err", err, 0);
        check("t6_busy", busy, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
